// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default payload width and line idle level.
// The receiver imports the same package so both ends agree on these values.
package uart_pkg;

    // Default payload width in bits.
    localparam int DATA_W_DEF = 8;

    // Level of the serial line when nothing is being sent; also the stop bit level.
    localparam logic IDLE_LEVEL = 1'b1;

    // Binary state encoding. Plain constants rather than an enum so older
    // code that compares against raw 3-bit values keeps working.
    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register plus bit counter for the UART transmitter.
// load captures a new byte and clears the counter; each shift moves the
// register one place towards the LSB and advances the counter, which stops
// at DATA_W-1. done flags the last payload bit; ser_bit is the current LSB.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift,
    output logic              done,
    output logic              ser_bit
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;
    logic [DATA_W-1:0] shifted;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    // Right-shift network: every bit takes its upper neighbour, the MSB fills with 0.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_shift
            if (gi == DATA_W - 1) begin : g_msb
                assign shifted[gi] = 1'b0;
            end else begin : g_mid
                assign shifted[gi] = shreg_q[gi + 1];
            end
        end
    endgenerate

    // Next-state logic: load wins over shift; the counter saturates at the last bit.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load) begin
            shreg_d = load_data;
            cnt_d   = '0;
        end else if (shift) begin
            shreg_d = shifted;
            if (cnt_q != CNT_LAST) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Register update with asynchronous clear.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign done    = (cnt_q == CNT_LAST);
    assign ser_bit = shreg_q[0];

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: accepts a byte on data_valid & ready and sends
// start bit, DATA_W payload bits LSB first, optional parity bit and stop bit.
// tx_out and busy are registered from the current state, so the line lags
// the FSM by one cycle: the start bit appears one cycle after the FSM
// enters START, and a byte accepted in STOP follows the stop bit directly.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic [DATA_W-1:0] p_data,
    input  logic              data_valid,
    input  logic              par_en,
    input  logic              parity,
    output logic              ready,
    output logic              busy,
    output logic [DATA_W-1:0] calc_data,
    output logic              calc_en,
    output logic              tx_out
);

    uart_state_t       state_q;
    uart_state_t       state_d;
    logic              par_en_q;
    logic              par_en_d;
    logic [DATA_W-1:0] calc_data_q;
    logic [DATA_W-1:0] calc_data_d;
    logic              calc_en_q;
    logic              calc_en_d;
    logic              tx_out_q;
    logic              tx_out_d;
    logic              busy_q;
    logic              busy_d;

    logic              accept;
    logic              ser_done;
    logic              ser_bit;
    logic              ser_shift;

    uart_tx_serializer #(
        .DATA_W (DATA_W)
    ) u_serializer (
        .clk1      (clk1),
        .rst       (rst),
        .load      (accept),
        .load_data (p_data),
        .shift     (ser_shift),
        .done      (ser_done),
        .ser_bit   (ser_bit)
    );

    // A new byte can be taken while idle or while the stop bit is being set up.
    always_comb begin
        ready = (state_q == ST_IDLE) || (state_q == ST_STOP);
    end

    assign accept    = data_valid & ready;
    assign ser_shift = (state_q == ST_DATA);

    // Frame sequencing: IDLE -> START -> DATA x DATA_W -> [PARITY] -> STOP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (ser_done) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                state_d = ST_STOP;
            end
            ST_STOP: begin
                state_d = accept ? ST_START : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Byte capture, parity-calculator handshake and line/busy values for the next cycle.
    always_comb begin
        par_en_d    = par_en_q;
        calc_data_d = calc_data_q;
        calc_en_d   = accept;
        if (accept) begin
            par_en_d    = par_en;
            calc_data_d = p_data;
        end

        busy_d = (state_q != ST_IDLE);

        case (state_q)
            ST_START:  tx_out_d = 1'b0;
            ST_DATA:   tx_out_d = ser_bit;
            ST_PARITY: tx_out_d = parity;
            default:   tx_out_d = IDLE_LEVEL;
        endcase
    end

    // State and output registers; reset drops the frame and returns the line to idle.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            par_en_q    <= 1'b0;
            calc_data_q <= '0;
            calc_en_q   <= 1'b0;
            tx_out_q    <= IDLE_LEVEL;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            par_en_q    <= par_en_d;
            calc_data_q <= calc_data_d;
            calc_en_q   <= calc_en_d;
            tx_out_q    <= tx_out_d;
            busy_q      <= busy_d;
        end
    end

    assign calc_data = calc_data_q;
    assign calc_en   = calc_en_q;
    assign tx_out    = tx_out_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame. The driver decides from its own frame
// model whether each request is taken, and pushes the expected line bits
// (start, payload LSB first, parity, stop) and the acceptance event into
// queues. A separate monitor samples the DUT every cycle and compares.
module tb_uart_tx_frame;

    localparam int W = 8;

    logic         clk1 = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] p_data = '0;
    logic         data_valid = 1'b0;
    logic         par_en = 1'b0;
    logic         parity;
    logic         ready;
    logic         busy;
    logic [W-1:0] calc_data;
    logic         calc_en;
    logic         tx_out;

    // Stand-in for the external parity calculator: even parity of the latched byte.
    assign parity = ^calc_data;

    uart_tx_frame #(
        .DATA_W (W)
    ) dut (
        .clk1       (clk1),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .parity     (parity),
        .ready      (ready),
        .busy       (busy),
        .calc_data  (calc_data),
        .calc_en    (calc_en),
        .tx_out     (tx_out)
    );

    always #5 clk1 = ~clk1;

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;

    always @(posedge clk1) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int   idx;
        logic tx;
        logic stop;
    } line_item_t;

    typedef struct {
        int           edge_n;
        logic [W-1:0] data;
    } acc_t;

    line_item_t   exp_q[$];
    acc_t         acc_q[$];
    int           ready_at = 0;
    logic [W-1:0] last_byte = '0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%b expected=%b", name, edge_cnt, act, exp);
        end
    endtask

    task automatic check_byte(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=0x%02h expected=0x%02h", name, edge_cnt, act, exp);
        end
    endtask

    task automatic push_item(input int idx, input logic tx, input logic stop);
        line_item_t it;
        it.idx  = idx;
        it.tx   = tx;
        it.stop = stop;
        exp_q.push_back(it);
    endtask

    // One cycle of stimulus; the model decides whether the coming edge accepts.
    task automatic drive(input logic dv, input logic [W-1:0] d, input logic pe);
        int   e;
        int   len;
        logic pbit;
        acc_t a;
        @(negedge clk1);
        data_valid = dv;
        p_data     = d;
        par_en     = pe;
        e = edge_cnt + 1;
        if (rst && dv && e >= ready_at) begin
            len  = W + 2 + (pe ? 1 : 0);
            pbit = (($countones(d) % 2) == 1);
            push_item(e + 1, 1'b0, 1'b0);
            for (int i = 0; i < W; i++) begin
                push_item(e + 2 + i, d[i], 1'b0);
            end
            if (pe) begin
                push_item(e + 2 + W, pbit, 1'b0);
            end
            push_item(e + len, 1'b1, 1'b1);
            a.edge_n = e;
            a.data   = d;
            acc_q.push_back(a);
            ready_at = e + len;
            $display("frame accepted edge=%0d data=0x%02h par_en=%0b len=%0d", e, d, pe, len);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, W'($urandom), 1'($urandom_range(0, 1)));
        end
    endtask

    // Asynchronous reset in the middle of a cycle, checked before any clock edge.
    task automatic do_reset();
        @(negedge clk1);
        data_valid = 1'b0;
        #1;
        rst = 1'b0;
        exp_q.delete();
        acc_q.delete();
        ready_at  = 0;
        last_byte = '0;
        #1;
        check_bit("async_rst_tx_out", tx_out, 1'b1);
        check_bit("async_rst_busy", busy, 1'b0);
        check_bit("async_rst_ready", ready, 1'b1);
        $display("reset asserted at cycle=%0d", edge_cnt);
        repeat (2) @(negedge clk1);
        rst = 1'b1;
    endtask

    // Monitor: compares line, busy, ready and parity-calculator handshake every cycle.
    initial begin
        int   k;
        logic exp_tx;
        logic exp_busy;
        logic exp_ready;
        logic exp_cen;
        forever begin
            @(posedge clk1);
            #3;
            k = edge_cnt;
            if (!rst) begin
                check_bit("rst_tx_out", tx_out, 1'b1);
                check_bit("rst_busy", busy, 1'b0);
                check_bit("rst_ready", ready, 1'b1);
                check_bit("rst_calc_en", calc_en, 1'b0);
                check_byte("rst_calc_data", calc_data, '0);
            end else begin
                exp_tx   = 1'b1;
                exp_busy = 1'b0;
                if (exp_q.size() > 0 && exp_q[0].idx == k) begin
                    exp_tx   = exp_q[0].tx;
                    exp_busy = 1'b1;
                    void'(exp_q.pop_front());
                end
                exp_ready = !(exp_q.size() > 0 && exp_q[0].idx == k + 1 && !exp_q[0].stop);
                exp_cen = 1'b0;
                if (acc_q.size() > 0 && acc_q[0].edge_n == k) begin
                    exp_cen   = 1'b1;
                    last_byte = acc_q[0].data;
                    void'(acc_q.pop_front());
                end
                check_bit("tx_out", tx_out, exp_tx);
                check_bit("busy", busy, exp_busy);
                check_bit("ready", ready, exp_ready);
                check_bit("calc_en", calc_en, exp_cen);
                check_byte("calc_data", calc_data, last_byte);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk1);
        check_bit("init_tx_out", tx_out, 1'b1);
        check_bit("init_busy", busy, 1'b0);
        check_bit("init_ready", ready, 1'b1);
        check_bit("init_calc_en", calc_en, 1'b0);
        check_byte("init_calc_data", calc_data, '0);
        rst = 1'b1;
        idle(2);

        // 0xA5 with parity: 11-cycle frame.
        drive(1'b1, 8'hA5, 1'b1);
        idle(13);

        // 0x01 without parity: 10-cycle frame.
        drive(1'b1, 8'h01, 1'b0);
        idle(12);

        // data_valid held high: 0x3C then 0xFF back to back.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, (i < 10) ? 8'h3C : 8'hFF, 1'b0);
        end
        idle(12);

        // Request in the middle of DATA is ignored.
        drive(1'b1, 8'h96, 1'b1);
        idle(3);
        drive(1'b1, 8'h00, 1'b0);
        idle(14);

        // Reset in the middle of DATA, then a complete new frame.
        drive(1'b1, 8'h5A, 1'b0);
        idle(4);
        do_reset();
        idle(2);
        drive(1'b1, 8'hC3, 1'b1);
        idle(14);

        // Random traffic, including inputs changing while a frame is in flight.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) == 0), W'($urandom), 1'($urandom_range(0, 1)));
        end
        idle(16);

        checks++;
        if (exp_q.size() != 0 || acc_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending_line=%0d pending_accepts=%0d expected=0", exp_q.size(), acc_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
